// File: rtl/fetch_pc_ctrl.sv
// fetch_pc_ctrl: next-PC scheduler arbitrating trap/branch/jump redirects against sequential fetch.
// Optional fetch halt state is built when FETCH_PC_CTRL_HALT_EN is defined.
module fetch_pc_ctrl #(
   parameter int unsigned         PC_WIDTH    = 64,
   parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
   parameter int unsigned         INSTR_BYTES = 4,
   parameter int unsigned         CNT_WIDTH   = 16
) (
   input  logic                 clk,
   input  logic                 rst,
`ifdef FETCH_PC_CTRL_HALT_EN
   input  logic                 halt_req_i,
   input  logic                 resume_i,
   output logic                 halted_o,
`endif
   input  logic [PC_WIDTH-1:0]  IF_pc_i,
   input  logic                 ID_ready_i,
   input  logic                 exc_req_i,
   input  logic [PC_WIDTH-1:0]  exc_pc_i,
   input  logic                 ex_br_req_i,
   input  logic [PC_WIDTH-1:0]  ex_br_pc_i,
   input  logic                 id_jmp_req_i,
   input  logic [PC_WIDTH-1:0]  id_jmp_pc_i,
   output logic [PC_WIDTH-1:0]  ifu_pc_next_o,
   output logic                 fetch_run_o,
   output logic                 flush_if_o,
   output logic                 flush_id_o,
   output logic [CNT_WIDTH-1:0] redirect_cnt_o
);
`ifdef FETCH_PC_CTRL_HALT_EN
   typedef enum logic [1:0] {BOOT, RUN, PEND, HALT} state_t;
`else
   typedef enum logic [1:0] {BOOT, RUN, PEND} state_t;
`endif
   state_t state, state_nxt;
   logic [1:0] in_cls, pend_cls, sel_cls;
   logic [PC_WIDTH-1:0] in_pc, pend_pc, sel_pc;
   logic apply;
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= BOOT;
      else     state <= state_nxt;
   // Class 0 means no redirect; pending only overrides the incoming winner on class >= incoming.
   always_comb begin
      in_cls  = exc_req_i ? 2'd3 : ex_br_req_i ? 2'd2 : id_jmp_req_i ? 2'd1 : 2'd0;
      in_pc   = exc_req_i ? exc_pc_i : ex_br_req_i ? ex_br_pc_i : id_jmp_req_i ? id_jmp_pc_i
              : IF_pc_i + PC_WIDTH'(INSTR_BYTES);
      sel_cls = (in_cls > pend_cls) ? in_cls : pend_cls;
      sel_pc  = (in_cls > pend_cls || pend_cls == 2'd0) ? in_pc : pend_pc;
      apply   = (state == RUN || state == PEND) && sel_cls != 2'd0 && ID_ready_i;
   end
   always_comb begin
      state_nxt = state;
      case (state)
         BOOT: state_nxt = RUN;
         RUN: begin
            state_nxt = (sel_cls != 2'd0 && !ID_ready_i) ? PEND : RUN;
`ifdef FETCH_PC_CTRL_HALT_EN
            if (halt_req_i) state_nxt = HALT;
`endif
         end
         PEND: state_nxt = ID_ready_i ? RUN : PEND;
`ifdef FETCH_PC_CTRL_HALT_EN
         HALT: state_nxt = !resume_i ? HALT : (sel_cls != 2'd0) ? PEND : RUN;
`endif
         default: state_nxt = BOOT;
      endcase
   end
   always_comb begin
      fetch_run_o   = state == RUN || state == PEND;
`ifdef FETCH_PC_CTRL_HALT_EN
      halted_o      = state == HALT;
      ifu_pc_next_o = (state == BOOT) ? RESET_PC : (state == HALT) ? IF_pc_i : sel_pc;
`else
      ifu_pc_next_o = (state == BOOT) ? RESET_PC : sel_pc;
`endif
   end
   // The pending slot tracks the best redirect seen since the last apply; BOOT ignores requests.
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         pend_cls       <= 2'd0;
         pend_pc        <= '0;
         flush_if_o     <= 1'b0;
         flush_id_o     <= 1'b0;
         redirect_cnt_o <= '0;
      end else begin
         flush_if_o <= apply;
         flush_id_o <= apply && sel_cls[1];
         if (apply && !(&redirect_cnt_o)) redirect_cnt_o <= redirect_cnt_o + CNT_WIDTH'(1);
         if (state != BOOT) begin
            pend_cls <= apply ? 2'd0 : sel_cls;
            pend_pc  <= sel_pc;
         end
      end
endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// tb_fetch_pc_ctrl: directed vector table, async-reset and halt sequences, then random stimulus vs a reference model.
module tb_fetch_pc_ctrl;
   typedef struct {
      logic        ready;
      logic [63:0] if_pc;
      logic        exc;
      logic [63:0] exc_pc;
      logic        br;
      logic [63:0] br_pc;
      logic        jmp;
      logic [63:0] jmp_pc;
      logic        halt;
      logic        resume;
      logic [63:0] exp_pc;
      logic        exp_run;
      logic        exp_halted;
      logic        exp_fif;
      logic        exp_fid;
      logic [3:0]  exp_cnt;
   } vec_t;

   logic clk = 0, rst = 1;
   logic [63:0] IF_pc_i = '0, exc_pc_i = '0, ex_br_pc_i = '0, id_jmp_pc_i = '0;
   logic ID_ready_i = 0, exc_req_i = 0, ex_br_req_i = 0, id_jmp_req_i = 0;
   logic [63:0] ifu_pc_next_o;
   logic fetch_run_o, flush_if_o, flush_id_o;
   logic [3:0] redirect_cnt_o;
`ifdef FETCH_PC_CTRL_HALT_EN
   logic halt_req_i = 0, resume_i = 0, halted_o;
`endif
   int n_chk = 0, n_fail = 0;
   logic        m_booted, m_halted;
   logic [1:0]  m_cls;
   logic [63:0] m_pc;
   logic [3:0]  m_cnt;
   vec_t tbl[$];

   always #5 clk = ~clk;

   fetch_pc_ctrl #(.CNT_WIDTH(4)) dut (
      .clk(clk), .rst(rst),
`ifdef FETCH_PC_CTRL_HALT_EN
      .halt_req_i(halt_req_i), .resume_i(resume_i), .halted_o(halted_o),
`endif
      .IF_pc_i(IF_pc_i), .ID_ready_i(ID_ready_i),
      .exc_req_i(exc_req_i), .exc_pc_i(exc_pc_i),
      .ex_br_req_i(ex_br_req_i), .ex_br_pc_i(ex_br_pc_i),
      .id_jmp_req_i(id_jmp_req_i), .id_jmp_pc_i(id_jmp_pc_i),
      .ifu_pc_next_o(ifu_pc_next_o), .fetch_run_o(fetch_run_o),
      .flush_if_o(flush_if_o), .flush_id_o(flush_id_o), .redirect_cnt_o(redirect_cnt_o)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic rdy, input logic [63:0] ifp,
                               input logic e, input logic [63:0] ep, input logic b, input logic [63:0] bp,
                               input logic j, input logic [63:0] jp, input logic [63:0] xpc, input logic xrun,
                               input logic xfif, input logic xfid, input logic [3:0] xcnt);
      vec_t v;
      v.ready = rdy; v.if_pc = ifp; v.exc = e; v.exc_pc = ep; v.br = b; v.br_pc = bp;
      v.jmp = j; v.jmp_pc = jp; v.halt = 0; v.resume = 0; v.exp_pc = xpc; v.exp_run = xrun;
      v.exp_halted = 0; v.exp_fif = xfif; v.exp_fid = xfid; v.exp_cnt = xcnt;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      ID_ready_i = v.ready; IF_pc_i = v.if_pc;
      exc_req_i = v.exc; exc_pc_i = v.exc_pc;
      ex_br_req_i = v.br; ex_br_pc_i = v.br_pc;
      id_jmp_req_i = v.jmp; id_jmp_pc_i = v.jmp_pc;
`ifdef FETCH_PC_CTRL_HALT_EN
      halt_req_i = v.halt; resume_i = v.resume;
`endif
   endtask

   // Inputs change at posedge+1; comb outputs checked at the negedge, registered ones after the next posedge.
   task automatic cyc(input vec_t v, input string tag);
      drive(v);
      #4;
      chk({tag, ".pc_next"}, ifu_pc_next_o, v.exp_pc);
      chk({tag, ".fetch_run"}, 64'(fetch_run_o), 64'(v.exp_run));
`ifdef FETCH_PC_CTRL_HALT_EN
      chk({tag, ".halted"}, 64'(halted_o), 64'(v.exp_halted));
`endif
      @(posedge clk);
      #1;
      chk({tag, ".flush_if"}, 64'(flush_if_o), 64'(v.exp_fif));
      chk({tag, ".flush_id"}, 64'(flush_id_o), 64'(v.exp_fid));
      chk({tag, ".cnt"}, 64'(redirect_cnt_o), 64'(v.exp_cnt));
   endtask

   task automatic do_reset();
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      rst = 1;
      @(posedge clk);
      #1 rst = 0;
      m_booted = 0; m_halted = 0; m_cls = 0; m_pc = 0; m_cnt = 0;
   endtask

   // Reference: best outstanding redirect as {class, target}; applied whenever fetch is running and ID accepts.
   task automatic model(inout vec_t v);
      logic [1:0] ic;
      logic [63:0] ipc;
      logic was_run;
      ic  = v.exc ? 2'd3 : v.br ? 2'd2 : v.jmp ? 2'd1 : 2'd0;
      ipc = v.exc ? v.exc_pc : v.br ? v.br_pc : v.jmp ? v.jmp_pc : v.if_pc + 64'd4;
      v.exp_fif = 0; v.exp_fid = 0; v.exp_halted = m_halted;
      if (!m_booted) begin
         v.exp_pc = 0; v.exp_run = 0; m_booted = 1;
      end else if (m_halted) begin
         v.exp_pc = v.if_pc; v.exp_run = 0;
         if (ic > m_cls) begin m_cls = ic; m_pc = ipc; end
         if (v.resume) m_halted = 0;
      end else begin
         was_run = m_cls == 0;
         if (ic > m_cls) begin m_cls = ic; m_pc = ipc; end
         v.exp_pc = (m_cls != 0) ? m_pc : ipc;
         v.exp_run = 1;
         if (m_cls != 0 && v.ready) begin
            v.exp_fif = 1; v.exp_fid = m_cls >= 2;
            m_cnt = (m_cnt == 4'd15) ? m_cnt : m_cnt + 4'd1;
            m_cls = 0;
         end
         if (was_run && v.halt) m_halted = 1;
      end
      v.exp_cnt = m_cnt;
   endtask

   initial begin
      vec_t v;
      //          rdy ifpc                    exc epc      br bpc      jmp jpc      pc          run fif fid cnt
      tbl.push_back(mk(1, 64'h0,               0, 0,       0, 0,       0, 0,       64'h0,      0, 0, 0, 0));
      tbl.push_back(mk(1, 64'h0,               0, 0,       0, 0,       0, 0,       64'h4,      1, 0, 0, 0));
      tbl.push_back(mk(1, 64'h4,               0, 0,       0, 0,       0, 0,       64'h8,      1, 0, 0, 0));
      tbl.push_back(mk(1, 64'h8,               0, 0,       0, 0,       0, 0,       64'hC,      1, 0, 0, 0));
      tbl.push_back(mk(1, 64'h1000,            0, 0,       1, 64'h2000, 0, 0,      64'h2000,   1, 1, 1, 1));
      tbl.push_back(mk(1, 64'h2000,            0, 0,       0, 0,       0, 0,       64'h2004,   1, 0, 0, 1));
      tbl.push_back(mk(0, 64'h2004,            0, 0,       0, 0,       1, 64'h3000, 64'h3000,  1, 0, 0, 1));
      tbl.push_back(mk(0, 64'h2004,            1, 64'h8000, 0, 0,      1, 64'h3000, 64'h8000,  1, 0, 0, 1));
      tbl.push_back(mk(0, 64'h2004,            1, 64'h8000, 0, 0,      1, 64'h3000, 64'h8000,  1, 0, 0, 1));
      tbl.push_back(mk(1, 64'h2004,            1, 64'h8000, 0, 0,      1, 64'h3000, 64'h8000,  1, 1, 1, 2));
      tbl.push_back(mk(1, 64'h8000,            0, 0,       0, 0,       0, 0,       64'h8004,   1, 0, 0, 2));
      tbl.push_back(mk(1, 64'h8004,            1, 64'h8000, 1, 64'h2000, 1, 64'h3000, 64'h8000, 1, 1, 1, 3));
      tbl.push_back(mk(1, 64'h8000,            0, 0,       0, 0,       0, 0,       64'h8004,   1, 0, 0, 3));
      tbl.push_back(mk(1, 64'h8004,            0, 0,       0, 0,       1, 64'h3000, 64'h3000,  1, 1, 0, 4));
      tbl.push_back(mk(1, 64'h3000,            0, 0,       0, 0,       1, 64'h3000, 64'h3000,  1, 1, 0, 5));
      tbl.push_back(mk(1, 64'h3000,            0, 0,       1, 64'h2000, 1, 64'h3000, 64'h2000, 1, 1, 1, 6));
      tbl.push_back(mk(1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0,   0, 0,       0, 0,       64'h0,      1, 0, 0, 6));
      tbl.push_back(mk(0, 64'h0,               0, 0,       1, 64'h2000, 0, 0,      64'h2000,   1, 0, 0, 6));
      tbl.push_back(mk(0, 64'h0,               0, 0,       1, 64'h2200, 0, 0,      64'h2000,   1, 0, 0, 6));
      tbl.push_back(mk(1, 64'h0,               0, 0,       0, 0,       1, 64'h3000, 64'h2000,  1, 1, 1, 7));
      tbl.push_back(mk(1, 64'h2000,            0, 0,       0, 0,       0, 0,       64'h2004,   1, 0, 0, 7));
      tbl.push_back(mk(0, 64'h2004,            0, 0,       1, 64'h2000, 0, 0,      64'h2000,   1, 0, 0, 7));

      #1;
      chk("rst.pc_next", ifu_pc_next_o, 64'h0);
      chk("rst.fetch_run", 64'(fetch_run_o), 64'h0);
      chk("rst.flush_if", 64'(flush_if_o), 64'h0);
      chk("rst.flush_id", 64'(flush_id_o), 64'h0);
      chk("rst.cnt", 64'(redirect_cnt_o), 64'h0);
      @(posedge clk);
      #1 rst = 0;
      foreach (tbl[i]) cyc(tbl[i], $sformatf("vec%0d", i));

      // Block now holds 0x2000 pending; an async reset mid-cycle must drop it without a flush.
      drive(mk(0, 64'h2004, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      #2 rst = 1;
      #1;
      chk("arst.pc_next", ifu_pc_next_o, 64'h0);
      chk("arst.fetch_run", 64'(fetch_run_o), 64'h0);
      chk("arst.flush_if", 64'(flush_if_o), 64'h0);
      chk("arst.flush_id", 64'(flush_id_o), 64'h0);
      chk("arst.cnt", 64'(redirect_cnt_o), 64'h0);
      @(posedge clk);
      #1 rst = 0;
      cyc(mk(1, 64'h0, 0, 0, 0, 0, 0, 0, 64'h0, 0, 0, 0, 0), "arst.boot");
      cyc(mk(1, 64'h0, 0, 0, 0, 0, 0, 0, 64'h4, 1, 0, 0, 0), "arst.run");

`ifdef FETCH_PC_CTRL_HALT_EN
      do_reset();
      cyc(mk(1, 64'h0,  0, 0, 0, 0, 0, 0, 64'h0,  0, 0, 0, 0), "halt.boot");
      cyc(mk(1, 64'h3C, 0, 0, 0, 0, 0, 0, 64'h40, 1, 0, 0, 0), "halt.run");
      v = mk(1, 64'h40, 0, 0, 0, 0, 0, 0, 64'h44, 1, 0, 0, 0); v.halt = 1;
      cyc(v, "halt.req");
      v = mk(1, 64'h40, 0, 0, 0, 0, 0, 0, 64'h40, 0, 0, 0, 0); v.exp_halted = 1;
      cyc(v, "halt.hold");
      v = mk(1, 64'h40, 0, 0, 1, 64'h500, 0, 0, 64'h40, 0, 0, 0, 0); v.exp_halted = 1;
      cyc(v, "halt.br");
      v.resume = 1;
      cyc(v, "halt.resume");
      cyc(mk(1, 64'h40,  0, 0, 1, 64'h500, 0, 0, 64'h500, 1, 1, 1, 1), "halt.apply");
      cyc(mk(1, 64'h500, 0, 0, 0, 0,       0, 0, 64'h504, 1, 0, 0, 1), "halt.after");
`endif

      do_reset();
      for (int i = 0; i < 600; i++) begin
         v.ready  = $urandom_range(0, 9) < 7;
         v.if_pc  = {$urandom(), $urandom()} & ~64'h3;
         v.exc    = $urandom_range(0, 9) == 0;
         v.exc_pc = {$urandom(), $urandom()};
         v.br     = $urandom_range(0, 5) == 0;
         v.br_pc  = {$urandom(), $urandom()};
         v.jmp    = $urandom_range(0, 4) == 0;
         v.jmp_pc = {$urandom(), $urandom()};
`ifdef FETCH_PC_CTRL_HALT_EN
         v.halt   = $urandom_range(0, 14) == 0;
         v.resume = $urandom_range(0, 3) == 0;
`else
         v.halt   = 0;
         v.resume = 0;
`endif
         model(v);
         cyc(v, $sformatf("rnd%0d", i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
